// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared state encoding, command indices and button arbitration
package oven_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    QSTART = 3'd2,
    ACK    = 3'd3,
    COOK   = 3'd4,
    PAUSE  = 3'd5,
    DONE   = 3'd6
  } oven_state_t;

  localparam int MAX_TIME = 3600;

  localparam int NUM_CMDS      = 7;
  localparam int CMD_ADD_10SEC = 0;
  localparam int CMD_ADD_1MIN  = 1;
  localparam int CMD_SET_30SEC = 2;
  localparam int CMD_START     = 3;
  localparam int CMD_PAUSE     = 4;
  localparam int CMD_RESUME    = 5;
  localparam int CMD_CLEAR     = 6;

  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_10SEC = 3'd1,
    BTN_1MIN  = 3'd2,
    BTN_START = 3'd3,
    BTN_STOP  = 3'd4
  } btn_t;

  // start_ok is btn_start already masked by an open door, so a blocked start
  // lets a lower-priority button through.
  function automatic btn_t pick_button(input logic stop, input logic start_ok,
                                       input logic one_min, input logic ten_sec);
    btn_t b;
    b = BTN_NONE;
    if (stop)          b = BTN_STOP;
    else if (start_ok) b = BTN_START;
    else if (one_min)  b = BTN_1MIN;
    else if (ten_sec)  b = BTN_10SEC;
    return b;
  endfunction

  function automatic logic [NUM_CMDS-1:0] add_pulse(input btn_t b);
    logic [NUM_CMDS-1:0] c;
    c = '0;
    if (b == BTN_1MIN)  c[CMD_ADD_1MIN]  = 1'b1;
    if (b == BTN_10SEC) c[CMD_ADD_10SEC] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/oven_cmd_sequencer.sv
// rtl/oven_cmd_sequencer.sv - front-panel FSM turning buttons and door into timer commands
module oven_cmd_sequencer
  import oven_pkg::*;
#(
  parameter int BEEP_CYCLES = 100_000_000,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_10sec,
  input  logic        btn_1min,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        door_open,
  input  logic [11:0] set_time_sec,
  input  logic        timer_running,
  input  logic        timer_paused,
  input  logic        timer_completed,
  output logic        add_10sec,
  output logic        add_1min,
  output logic        set_30sec,
  output logic        start_timer,
  output logic        pause_timer,
  output logic        resume_timer,
  output logic        clear_timer,
  output logic        magnetron_on,
  output logic        lamp_on,
  output logic        buzzer_on,
  output logic [2:0]  oven_state
);

  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  oven_state_t         state, state_d;
  logic [NUM_CMDS-1:0] cmd_q, cmd_d;
  logic [AW-1:0]       ack_cnt, ack_d;
  logic [BW-1:0]       beep_cnt, beep_d;
  logic                door_s;
  logic                any_btn;
  btn_t                btn;

  // The timer's paused flag carries nothing the sequencer's own state lacks.
  logic unused_status;
  assign unused_status = timer_paused;

  sync_2ff u_door_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (door_open),
    .q       (door_s)
  );

  assign btn     = pick_button(btn_stop, btn_start & ~door_s, btn_1min, btn_10sec);
  assign any_btn = btn_10sec | btn_1min | btn_start | btn_stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      ack_cnt  <= '0;
      beep_cnt <= '0;
    end else begin
      state    <= state_d;
      cmd_q    <= cmd_d;
      ack_cnt  <= ack_d;
      beep_cnt <= beep_d;
    end
  end

  // Counters default to zero so every entry into ACK/DONE starts a fresh count.
  always_comb begin
    state_d = state;
    cmd_d   = '0;
    ack_d   = '0;
    beep_d  = '0;
    case (state)
      IDLE: begin
        if (btn == BTN_START) begin
          cmd_d[CMD_SET_30SEC] = 1'b1;
          state_d              = QSTART;
        end else if (add_pulse(btn) != '0) begin
          cmd_d   = add_pulse(btn);
          state_d = SET;
        end
      end
      SET: begin
        if (btn == BTN_STOP) begin
          cmd_d[CMD_CLEAR] = 1'b1;
          state_d          = IDLE;
        end else if (btn == BTN_START) begin
          if (set_time_sec != '0) begin
            cmd_d[CMD_START] = 1'b1;
            state_d          = ACK;
          end
        end else begin
          cmd_d = add_pulse(btn);
        end
      end
      QSTART: begin
        cmd_d[CMD_START] = 1'b1;
        state_d          = ACK;
      end
      ACK: begin
        if (door_s) begin
          cmd_d[CMD_CLEAR] = 1'b1;
          state_d          = IDLE;
        end else if (timer_running) begin
          state_d = COOK;
        end else if (ack_cnt == ACK_LAST) begin
          cmd_d[CMD_CLEAR] = 1'b1;
          state_d          = IDLE;
        end else begin
          ack_d = ack_cnt + 1'b1;
        end
      end
      COOK: begin
        if (door_s || btn == BTN_STOP) begin
          cmd_d[CMD_PAUSE] = 1'b1;
          state_d          = PAUSE;
        end else if (timer_completed) begin
          state_d = DONE;
        end
      end
      PAUSE: begin
        if (btn == BTN_STOP) begin
          cmd_d[CMD_CLEAR] = 1'b1;
          state_d          = IDLE;
        end else if (btn == BTN_START) begin
          cmd_d[CMD_RESUME] = 1'b1;
          state_d           = COOK;
        end else begin
          cmd_d = add_pulse(btn);
        end
      end
      DONE: begin
        if (door_s || any_btn || beep_cnt == BEEP_LAST) begin
          cmd_d[CMD_CLEAR] = 1'b1;
          state_d          = IDLE;
        end else begin
          beep_d = beep_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign add_10sec    = cmd_q[CMD_ADD_10SEC];
  assign add_1min     = cmd_q[CMD_ADD_1MIN];
  assign set_30sec    = cmd_q[CMD_SET_30SEC];
  assign start_timer  = cmd_q[CMD_START];
  assign pause_timer  = cmd_q[CMD_PAUSE];
  assign resume_timer = cmd_q[CMD_RESUME];
  assign clear_timer  = cmd_q[CMD_CLEAR];

  assign magnetron_on = (state == COOK);
  assign lamp_on      = (state == COOK) | door_s;
  assign buzzer_on    = (state == DONE);
  assign oven_state   = state;

endmodule

// File: tb/tb_oven_cmd_sequencer.sv
// tb/tb_oven_cmd_sequencer.sv - randomized and directed bench with a behavioural oven model
module tb_oven_cmd_sequencer;

  localparam int BEEP = 16;
  localparam int ACKT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_10sec, btn_1min, btn_start, btn_stop, door_open;
  logic [11:0] set_time_sec;
  logic        timer_running, timer_paused, timer_completed;
  logic        add_10sec, add_1min, set_30sec, start_timer, pause_timer, resume_timer, clear_timer;
  logic        magnetron_on, lamp_on, buzzer_on;
  logic [2:0]  oven_state;

  int n_checks = 0;
  int n_errors = 0;

  oven_cmd_sequencer #(.BEEP_CYCLES(BEEP), .ACK_TIMEOUT(ACKT)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_10sec(btn_10sec), .btn_1min(btn_1min), .btn_start(btn_start), .btn_stop(btn_stop),
    .door_open(door_open), .set_time_sec(set_time_sec),
    .timer_running(timer_running), .timer_paused(timer_paused), .timer_completed(timer_completed),
    .add_10sec(add_10sec), .add_1min(add_1min), .set_30sec(set_30sec), .start_timer(start_timer),
    .pause_timer(pause_timer), .resume_timer(resume_timer), .clear_timer(clear_timer),
    .magnetron_on(magnetron_on), .lamp_on(lamp_on), .buzzer_on(buzzer_on), .oven_state(oven_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: named modes, named commands, countdown allowances.
  string m_mode = "IDLE";
  string m_cmd  = "";
  string m_btn, m_nm, m_nc;
  bit    m_d1 = 1'b0, m_ds = 1'b0;
  int    m_ack_left = 0, m_beep_left = 0;

  function automatic string add_name(input string b);
    return (b == "1min") ? "add_1min" : "add_10sec";
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = "IDLE"; m_cmd = ""; m_d1 = 1'b0; m_ds = 1'b0;
      m_ack_left = 0; m_beep_left = 0;
    end else begin
      m_btn = "";
      if (btn_stop)                  m_btn = "stop";
      else if (btn_start && !m_ds)   m_btn = "start";
      else if (btn_1min)             m_btn = "1min";
      else if (btn_10sec)            m_btn = "10sec";
      m_nm = m_mode; m_nc = "";
      if (m_mode == "IDLE") begin
        if (m_btn == "start") begin m_nc = "set_30sec"; m_nm = "QSTART"; end
        else if (m_btn == "1min" || m_btn == "10sec") begin m_nc = add_name(m_btn); m_nm = "SET"; end
      end else if (m_mode == "SET") begin
        if (m_btn == "stop") begin m_nc = "clear_timer"; m_nm = "IDLE"; end
        else if (m_btn == "start") begin
          if (set_time_sec > 0) begin m_nc = "start_timer"; m_nm = "ACK"; m_ack_left = ACKT; end
        end else if (m_btn != "") m_nc = add_name(m_btn);
      end else if (m_mode == "QSTART") begin
        m_nc = "start_timer"; m_nm = "ACK"; m_ack_left = ACKT;
      end else if (m_mode == "ACK") begin
        if (m_ds) begin m_nc = "clear_timer"; m_nm = "IDLE"; end
        else if (timer_running) m_nm = "COOK";
        else begin
          m_ack_left--;
          if (m_ack_left == 0) begin m_nc = "clear_timer"; m_nm = "IDLE"; end
        end
      end else if (m_mode == "COOK") begin
        if (m_ds || m_btn == "stop") begin m_nc = "pause_timer"; m_nm = "PAUSE"; end
        else if (timer_completed) begin m_nm = "DONE"; m_beep_left = BEEP; end
      end else if (m_mode == "PAUSE") begin
        if (m_btn == "stop") begin m_nc = "clear_timer"; m_nm = "IDLE"; end
        else if (m_btn == "start") begin m_nc = "resume_timer"; m_nm = "COOK"; end
        else if (m_btn != "") m_nc = add_name(m_btn);
      end else if (m_mode == "DONE") begin
        if (m_ds || btn_10sec || btn_1min || btn_start || btn_stop) begin
          m_nc = "clear_timer"; m_nm = "IDLE";
        end else begin
          m_beep_left--;
          if (m_beep_left == 0) begin m_nc = "clear_timer"; m_nm = "IDLE"; end
        end
      end
      m_mode = m_nm; m_cmd = m_nc;
      m_ds = m_d1; m_d1 = door_open;
    end
  end

  function automatic logic [2:0] state_code(input string s);
    if (s == "SET")    return 3'd1;
    if (s == "QSTART") return 3'd2;
    if (s == "ACK")    return 3'd3;
    if (s == "COOK")   return 3'd4;
    if (s == "PAUSE")  return 3'd5;
    if (s == "DONE")   return 3'd6;
    return 3'd0;
  endfunction

  function automatic string dut_cmd();
    string s; int n;
    s = ""; n = 0;
    if (add_10sec)    begin s = "add_10sec";    n++; end
    if (add_1min)     begin s = "add_1min";     n++; end
    if (set_30sec)    begin s = "set_30sec";    n++; end
    if (start_timer)  begin s = "start_timer";  n++; end
    if (pause_timer)  begin s = "pause_timer";  n++; end
    if (resume_timer) begin s = "resume_timer"; n++; end
    if (clear_timer)  begin s = "clear_timer";  n++; end
    if (n > 1) s = "several";
    return s;
  endfunction

  task automatic compare_all();
    logic [5:0] exp_o, got_o;
    string dc;
    dc = dut_cmd();
    n_checks++;
    if (dc != m_cmd) begin
      n_errors++;
      $display("FAIL cmd at %0t: got '%s' expected '%s'", $time, dc, m_cmd);
    end
    exp_o = {m_mode == "COOK", (m_mode == "COOK") || m_ds, m_mode == "DONE", state_code(m_mode)};
    got_o = {magnetron_on, lamp_on, buzzer_on, oven_state};
    n_checks++;
    if (got_o !== exp_o) begin
      n_errors++;
      $display("FAIL outputs at %0t: got mag/lamp/buz/state=%b expected %b (mode %s)",
               $time, got_o, exp_o, m_mode);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (reset_n) compare_all();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic press(input bit s10, input bit s60, input bit sst, input bit ssp);
    btn_10sec = s10; btn_1min = s60; btn_start = sst; btn_stop = ssp;
    tick();
    btn_10sec = 1'b0; btn_1min = 1'b0; btn_start = 1'b0; btn_stop = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    btn_10sec = 1'b0; btn_1min = 1'b0; btn_start = 1'b0; btn_stop = 1'b0;
    door_open = 1'b0; set_time_sec = '0;
    timer_running = 1'b0; timer_paused = 1'b0; timer_completed = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({add_10sec, add_1min, set_30sec, start_timer, pause_timer, resume_timer,
        clear_timer, magnetron_on, lamp_on, buzzer_on, oven_state}), 0);
    reset_n = 1'b1;
    tick();

    // two minutes then start
    press(0, 1, 0, 0);
    chk("t1_add_1min_a", int'(add_1min), 1);
    chk("t1_state_set", int'(oven_state), 1);
    press(0, 1, 0, 0);
    chk("t1_add_1min_b", int'(add_1min), 1);
    set_time_sec = 12'd120;
    press(0, 0, 1, 0);
    chk("t1_start_timer", int'(start_timer), 1);
    chk("t1_state_ack", int'(oven_state), 3);
    timer_running = 1'b1;
    tick();
    chk("t1_state_cook", int'(oven_state), 4);
    chk("t1_magnetron", int'(magnetron_on), 1);

    // door opens mid-cook, then close and resume
    door_open = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); n++;
      if (pause_timer) break;
    end
    chk("t3_pause_latency", n, 3);
    chk("t3_magnetron_off", int'(magnetron_on), 0);
    chk("t3_lamp_on", int'(lamp_on), 1);
    chk("t3_state_pause", int'(oven_state), 5);
    timer_running = 1'b0; timer_paused = 1'b1;
    door_open = 1'b0;
    repeat (3) tick();
    chk("t3_lamp_off", int'(lamp_on), 0);
    press(0, 0, 1, 0);
    chk("t3_resume", int'(resume_timer), 1);
    chk("t3_state_cook", int'(oven_state), 4);
    timer_running = 1'b1; timer_paused = 1'b0;
    tick();

    // stop beats start in the same cycle
    press(0, 0, 1, 1);
    chk("t4_pause_only", int'({start_timer, pause_timer, resume_timer}), 3'b010);
    chk("t4_state_pause", int'(oven_state), 5);
    timer_running = 1'b0;
    press(0, 0, 0, 1);
    chk("t4_clear", int'(clear_timer), 1);
    chk("t4_state_idle", int'(oven_state), 0);

    // quick start
    press(0, 0, 1, 0);
    chk("t2_set_30sec", int'(set_30sec), 1);
    chk("t2_state_qstart", int'(oven_state), 2);
    tick();
    chk("t2_start_timer", int'(start_timer), 1);
    timer_running = 1'b1;
    tick();
    chk("t2_state_cook", int'(oven_state), 4);

    // completion beep
    timer_completed = 1'b1; timer_running = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      timer_completed = 1'b0;
      if (buzzer_on) n++;
      if (clear_timer) break;
    end
    chk("t5_buzzer_cycles", n, BEEP);
    chk("t5_clear", int'(clear_timer), 1);
    chk("t5_state_idle", int'(oven_state), 0);

    // start never acknowledged
    press(0, 1, 0, 0);
    set_time_sec = 12'd30;
    press(0, 0, 1, 0);
    chk("t6_start_timer", int'(start_timer), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (clear_timer) break;
    end
    chk("t6_ack_timeout", n, ACKT);
    chk("t6_state_idle", int'(oven_state), 0);

    // reset in the middle of cooking
    press(0, 0, 1, 0);
    timer_running = 1'b1;
    repeat (2) tick();
    chk("t7_state_cook", int'(oven_state), 4);
    #3 reset_n = 1'b0;
    #1 chk("t7_reset_outputs", int'({add_10sec, add_1min, set_30sec, start_timer, pause_timer,
           resume_timer, clear_timer, magnetron_on, lamp_on, buzzer_on, oven_state}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t7_no_clear", int'(clear_timer), 0);
    chk("t7_state_idle", int'(oven_state), 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      btn_10sec = ($urandom_range(0, 9) == 0);
      btn_1min  = ($urandom_range(0, 9) == 0);
      btn_start = ($urandom_range(0, 5) == 0);
      btn_stop  = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 29) == 0) door_open = ~door_open;
      set_time_sec = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 3600));
      if ($urandom_range(0, 3) == 0) timer_running = 1'($urandom_range(0, 1));
      timer_completed = ($urandom_range(0, 19) == 0);
      timer_paused    = 1'($urandom_range(0, 1));
      if (i == 2000) reset_n = 1'b0;
      if (i == 2002) reset_n = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
